// File: rtl/op8_serial_seq.sv
// Bit-serial sequencer for an external 8-function 1-bit logic unit; operands are fed LSB-first, one bit per cycle.
// Latency: res_valid rises exactly WIDTH cycles after the accepting edge; request-to-request spacing is at least WIDTH+2.
// Backpressure: start_ready is low in RUN/DONE (no queuing); the result is held in DONE until res_ready.
// Optional feature: define OP8_SEQ_PARITY_EN to add the registered result_par (= ^result) output.
module op8_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       op_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             lu_a,
  output logic             lu_b,
  output logic [2:0]       lu_s,
`ifdef OP8_SEQ_PARITY_EN
  output logic             result_par,
`endif
  input  logic             lu_out
);

  // Bit counter is just wide enough to index WIDTH-1
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_start_ready;
  logic             r_res_valid;
  logic             r_busy;
  logic             r_lu_a;
  logic             r_lu_b;
  logic [2:0]       r_lu_s;
`ifdef OP8_SEQ_PARITY_EN
  logic             r_par;
`endif

  // Index of the bit that will be presented to the logic unit on the next RUN cycle
  logic [CW-1:0]    w_cnt_inc;
  assign w_cnt_inc = r_cnt + CW'(1);

  // Sequencer FSM; the logic-unit drive signals are registered one bit ahead so they
  // always show operand bit r_cnt while in RUN and are zero everywhere else
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_op          <= 3'b000;
      r_a           <= '0;
      r_b           <= '0;
      r_result      <= '0;
      r_start_ready <= 1'b0;
      r_res_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_lu_a        <= 1'b0;
      r_lu_b        <= 1'b0;
      r_lu_s        <= 3'b000;
`ifdef OP8_SEQ_PARITY_EN
      r_par         <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // start_ready comes up one cycle after reset release
          r_start_ready <= 1'b1;
          if (start_valid && r_start_ready) begin
            r_a           <= op_a;
            r_b           <= op_b;
            r_op          <= op_sel;
            r_cnt         <= '0;
            r_state       <= S_RUN;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
            r_lu_a        <= op_a[0];
            r_lu_b        <= op_b[0];
            r_lu_s        <= op_sel;
          end
        end

        S_RUN: begin
          r_result[r_cnt] <= lu_out;
`ifdef OP8_SEQ_PARITY_EN
          // Swap the old bit's contribution for the new one so parity tracks ^result
          r_par <= r_par ^ r_result[r_cnt] ^ lu_out;
`endif
          if (r_cnt == LAST) begin
            r_state     <= S_DONE;
            r_cnt       <= '0;
            r_res_valid <= 1'b1;
            r_lu_a      <= 1'b0;
            r_lu_b      <= 1'b0;
            r_lu_s      <= 3'b000;
          end else begin
            r_cnt  <= w_cnt_inc;
            r_lu_a <= r_a[w_cnt_inc];
            r_lu_b <= r_b[w_cnt_inc];
          end
        end

        S_DONE: begin
          // start_valid is ignored here; a pending request waits for the next IDLE cycle
          if (res_ready) begin
            r_state       <= S_IDLE;
            r_res_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
          end
        end

        default: begin
          r_state       <= S_IDLE;
          r_cnt         <= '0;
          r_res_valid   <= 1'b0;
          r_busy        <= 1'b0;
          r_start_ready <= 1'b0;
          r_lu_a        <= 1'b0;
          r_lu_b        <= 1'b0;
          r_lu_s        <= 3'b000;
        end
      endcase
    end
  end

  assign start_ready = r_start_ready;
  assign res_valid   = r_res_valid;
  assign result      = r_result;
  assign busy        = r_busy;
  assign lu_a        = r_lu_a;
  assign lu_b        = r_lu_b;
  assign lu_s        = r_lu_s;
`ifdef OP8_SEQ_PARITY_EN
  assign result_par  = r_par;
`endif

endmodule

// File: tb/tb_op8_serial_seq.sv
// Self-checking bench for op8_serial_seq with a behavioural logic unit attached.
// Reference results are computed word-wide from the opcode table.
// Define OP8_SEQ_PARITY_EN for both files to also check result_par.
module tb_op8_serial_seq;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         start_valid = 1'b0;
  logic         res_ready = 1'b0;
  logic [2:0]   op_sel = 3'b000;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         start_ready;
  logic         res_valid;
  logic         busy;
  logic         lu_a;
  logic         lu_b;
  logic [2:0]   lu_s;
  logic         lu_out;
  logic [W-1:0] result;
`ifdef OP8_SEQ_PARITY_EN
  logic         result_par;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  // 1-bit logic unit: XOR/AND/OR/NAND/NOR/NOTA/NOTB/XNOR
  function automatic logic lu_fn(input logic [2:0] s, input logic a, input logic b);
    case (s)
      3'd0:    return a ^ b;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~a;
      3'd6:    return ~b;
      default: return ~(a ^ b);
    endcase
  endfunction

  assign lu_out = lu_fn(lu_s, lu_a, lu_b);

  // Whole-word expected result
  function automatic logic [W-1:0] ref_word(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    case (s)
      3'd0:    return a ^ b;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~a;
      3'd6:    return ~b;
      default: return ~(a ^ b);
    endcase
  endfunction

  op8_serial_seq #(.WIDTH(W)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_sel      (op_sel),
    .op_a        (op_a),
    .op_b        (op_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .busy        (busy),
    .lu_a        (lu_a),
    .lu_b        (lu_b),
    .lu_s        (lu_s),
`ifdef OP8_SEQ_PARITY_EN
    .result_par  (result_par),
`endif
    .lu_out      (lu_out)
  );

  // All stimulus and sampling happens 1 time unit after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one request, record the per-cycle logic-unit drive, wait for the result,
  // hold it for 'hold' cycles, then retire it
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, output logic [W-1:0] res, output int lat,
                       output logic [W-1:0] ra, output logic [W-1:0] rb, output logic s_ok);
    int guard;
    res = '0; lat = -1; ra = '0; rb = '0; s_ok = 1'b0;
    op_sel = op; op_a = a; op_b = b; start_valid = 1'b1;
    guard = 0;
    while (!start_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!start_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: start_ready=%0b after %0d cycles, required 1", start_ready, guard);
      start_valid = 1'b0;
      return;
    end
    tick();
    start_valid = 1'b0;
    lat = 0;
    s_ok = 1'b1;
    while (!res_valid && lat < 100) begin
      if (lat < W) begin
        ra[lat] = lu_a;
        rb[lat] = lu_b;
        if (lu_s !== op) s_ok = 1'b0;
      end
      tick();
      lat++;
    end
    if (!res_valid) begin
      total++; bad++;
      $display("FAIL result_timeout: res_valid=%0b after %0d cycles, required 1", res_valid, lat);
      return;
    end
    res = result;
    repeat (hold) tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [W+7:0] outs;
    RST_N = 1'b0;
    tick();
    tick();
    outs = {start_ready, res_valid, busy, lu_a, lu_b, lu_s, result};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
`ifdef OP8_SEQ_PARITY_EN
    total++;
    if (result_par !== 1'b0) begin
      bad++;
      $display("FAIL reset_parity: got %0b, required 0", result_par);
    end
`endif
    RST_N = 1'b1;
    tick();
    total++;
    if (start_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: start_ready=%0b busy=%0b, required 1/0", start_ready, busy);
    end
  endtask

  task automatic test_xor();
    logic [W-1:0] res, ra, rb;
    int lat;
    logic s_ok;
    do_op(3'b000, 8'hA5, 8'h3C, 0, res, lat, ra, rb, s_ok);
    total++;
    if (res !== 8'h99) begin
      bad++;
      $display("FAIL xor_result: got %h, required 99", res);
    end
    total++;
    if (lat !== W) begin
      bad++;
      $display("FAIL xor_latency: got %0d, required %0d", lat, W);
    end
    total++;
    if (ra !== 8'hA5 || rb !== 8'h3C) begin
      bad++;
      $display("FAIL xor_lu_seq: lu_a=%h lu_b=%h, required A5/3C", ra, rb);
    end
    total++;
    if (s_ok !== 1'b1) begin
      bad++;
      $display("FAIL xor_lu_s: constant-select flag %0b, required 1", s_ok);
    end
    total++;
    if (busy !== 1'b0 || start_ready !== 1'b1 || res_valid !== 1'b0 || {lu_a, lu_b, lu_s} !== 5'b0) begin
      bad++;
      $display("FAIL xor_retire: busy=%0b rdy=%0b vld=%0b lu=%b, required 0/1/0/00000",
               busy, start_ready, res_valid, {lu_a, lu_b, lu_s});
    end
  endtask

  task automatic test_opcodes();
    logic [W-1:0] res, ra, rb, a, b;
    int lat;
    logic s_ok;
    do_op(3'b101, 8'hF0, 8'h00, 1, res, lat, ra, rb, s_ok);
    total++;
    if (res !== 8'h0F) begin bad++; $display("FAIL nota: got %h, required 0F", res); end
    do_op(3'b111, 8'h5A, 8'h5A, 0, res, lat, ra, rb, s_ok);
    total++;
    if (res !== 8'hFF) begin bad++; $display("FAIL xnor: got %h, required FF", res); end
    do_op(3'b011, 8'hFF, 8'h0F, 2, res, lat, ra, rb, s_ok);
    total++;
    if (res !== 8'hF0) begin bad++; $display("FAIL nand: got %h, required F0", res); end
    for (int op = 0; op < 8; op++) begin
      a = W'($urandom);
      b = W'($urandom);
      do_op(3'(op), a, b, 0, res, lat, ra, rb, s_ok);
      total++;
      if (res !== ref_word(3'(op), a, b)) begin
        bad++;
        $display("FAIL sweep_op%0d: got %h, required %h", op, res, ref_word(3'(op), a, b));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a2, b2, held, exp2;
    int guard;
    a2 = W'($urandom) | 8'h01;
    b2 = W'($urandom);
    op_sel = 3'b010; op_a = 8'h12; op_b = 8'h40; start_valid = 1'b1;
    guard = 0;
    while (!start_ready && guard < 50) begin tick(); guard++; end
    tick();
    start_valid = 1'b0;
    guard = 0;
    while (!res_valid && guard < 50) begin tick(); guard++; end
    held = result;
    total++;
    if (held !== 8'h52) begin bad++; $display("FAIL bp_first: got %h, required 52", held); end
    op_sel = 3'b000; op_a = a2; op_b = b2; start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (result !== held || res_valid !== 1'b1 || start_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold%0d: res=%h vld=%0b rdy=%0b busy=%0b, required %h/1/0/1",
                 i, result, res_valid, start_ready, busy, held);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || start_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_idle: busy=%0b vld=%0b rdy=%0b, required 0/0/1", busy, res_valid, start_ready);
    end
    tick();
    start_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || lu_a !== a2[0]) begin
      bad++;
      $display("FAIL bp_accept: busy=%0b lu_a=%0b, required 1/%0b", busy, lu_a, a2[0]);
    end
    guard = 0;
    while (!res_valid && guard < 50) begin tick(); guard++; end
    exp2 = a2 ^ b2;
    total++;
    if (result !== exp2) begin bad++; $display("FAIL bp_second: got %h, required %h", result, exp2); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [W+7:0] outs;
    logic [W-1:0] res, ra, rb;
    int lat, guard;
    logic s_ok;
    op_sel = 3'b010; op_a = 8'hFF; op_b = 8'hFF; start_valid = 1'b1;
    guard = 0;
    while (!start_ready && guard < 50) begin tick(); guard++; end
    tick();
    start_valid = 1'b0;
    repeat (3) tick();
    RST_N = 1'b0;
    #1;
    outs = {start_ready, res_valid, busy, lu_a, lu_b, lu_s, result};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got %h, required 0", outs);
    end
    tick();
    RST_N = 1'b1;
    do_op(3'b001, 8'hC3, 8'hFF, 0, res, lat, ra, rb, s_ok);
    total++;
    if (res !== 8'hC3) begin bad++; $display("FAIL midreset_and: got %h, required C3", res); end
  endtask

  task automatic test_random();
    logic [W-1:0] res, ra, rb, a, b;
    logic [2:0] op;
    int lat;
    logic s_ok;
    for (int n = 0; n < 24; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = W'($urandom);
      do_op(op, a, b, $urandom_range(0, 3), res, lat, ra, rb, s_ok);
      total++;
      if (res !== ref_word(op, a, b) || lat !== W || ra !== a || rb !== b || s_ok !== 1'b1) begin
        bad++;
        $display("FAIL rand%0d: op=%0d res=%h lat=%0d lu_a=%h lu_b=%h s=%0b, required %h/%0d/%h/%h/1",
                 n, op, res, lat, ra, rb, s_ok, ref_word(op, a, b), W, a, b);
      end
    end
  endtask

  task automatic test_parity();
`ifdef OP8_SEQ_PARITY_EN
    logic [W-1:0] res, ra, rb;
    int lat;
    logic s_ok;
    do_op(3'b001, 8'h07, 8'hFF, 0, res, lat, ra, rb, s_ok);
    total++;
    if (res !== 8'h07 || result_par !== 1'b1) begin
      bad++;
      $display("FAIL par_and: res=%h par=%0b, required 07/1", res, result_par);
    end
    do_op(3'b000, 8'hA5, 8'h3C, 0, res, lat, ra, rb, s_ok);
    total++;
    if (res !== 8'h99 || result_par !== 1'b0) begin
      bad++;
      $display("FAIL par_xor: res=%h par=%0b, required 99/0", res, result_par);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, exp;
    logic [2:0] op;
    int acc[$];
    int nres, guard;
    logic pb;
    a = W'($urandom); b = W'($urandom); op = 3'($urandom_range(0, 7));
    exp = ref_word(op, a, b);
    op_sel = op; op_a = a; op_b = b; start_valid = 1'b1; res_ready = 1'b1;
    pb = busy;
    nres = 0;
    for (int c = 0; c < 4 * (W + 2); c++) begin
      tick();
      if (busy && !pb) acc.push_back(c);
      if (res_valid) begin
        nres++;
        total++;
        if (result !== exp) begin bad++; $display("FAIL b2b_result: got %h, required %h", result, exp); end
`ifdef OP8_SEQ_PARITY_EN
        total++;
        if (result_par !== ^exp) begin bad++; $display("FAIL b2b_par: got %0b, required %0b", result_par, ^exp); end
`endif
      end
      pb = busy;
    end
    start_valid = 1'b0;
    guard = 0;
    while (busy && guard < 50) begin tick(); guard++; end
    res_ready = 1'b0;
    total++;
    if (acc.size() < 3 || nres < 3) begin
      bad++;
      $display("FAIL b2b_count: accepts=%0d results=%0d, required at least 3 each", acc.size(), nres);
    end
    for (int i = 1; i < acc.size(); i++) begin
      total++;
      if (acc[i] - acc[i-1] !== W + 2) begin
        bad++;
        $display("FAIL b2b_spacing%0d: got %0d, required %0d", i, acc[i] - acc[i-1], W + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_xor();
    test_opcodes();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_parity();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
